// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_loader_pkg;

  localparam int          LEN_W     = 16;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;  // addi x0,x0,0

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, RUN} loader_state_t;

  // A load length is usable only if it is a whole, nonzero number of words that fits in imem.
  function automatic logic len_legal(input logic [LEN_W-1:0] len, input int mem_bytes);
    return (len != '0) && (len[1:0] == 2'b00) && (int'(len) <= mem_bytes);
  endfunction

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// Packs a byte stream little-endian into 32-bit words; first byte of a word lands in [7:0].
module imem_boot_loader_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0]      lane;
  logic [3:0][7:0] lanes;

  // Lane register and lane counter; clear drops any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane  <= '0;
      lanes <= '0;
    end else if (clear) begin
      lane  <= '0;
      lanes <= '0;
    end else if (accept) begin
      lanes[lane] <= data;
      lane        <= lane + 2'd1;
    end
  end

  assign word      = lanes;
  // High in the cycle the fourth byte of a word is taken; the word is complete on the next edge.
  assign word_full = accept && (lane == 2'd3);

endmodule

// File: rtl/imem_boot_loader.sv
// Owns imem between a byte-stream program loader and core fetch.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int          MEM_BYTES = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter bit          BOOT_RUN  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             LoadStart,
  input  logic [LEN_W-1:0] LoadLength,
  input  logic [7:0]       ByteData,
  input  logic             ByteValid,
  output logic             ByteReady,
  input  logic [31:0]      FetchAddress,
  output logic [31:0]      Instruction,
  output logic [31:0]      MemAddress,
  output logic [31:0]      MemWrData,
  output logic             MemWrEn,
  input  logic [31:0]      MemRdData,
  output logic             CoreRun,
  output logic             LoadDone,
  output logic             LoadError
);

  localparam loader_state_t RESET_STATE = BOOT_RUN ? RUN : IDLE;

  loader_state_t    state_q, state_d;
  logic [LEN_W-1:0] count, len_q;
  logic [31:0]      addr;
  logic             start_ok, start_bad, accept, word_full, last_word;

  assign accept    = ByteValid && (state_q == LOAD);
  assign last_word = (count == len_q);

  imem_boot_loader_byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start_ok),
    .accept    (accept),
    .data      (ByteData),
    .word      (MemWrData),
    .word_full (word_full)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RESET_STATE;
    else        state_q <= state_d;
  end

  // Next state; LoadStart is only honoured while the loader is not mid-load.
  always_comb begin
    state_d   = state_q;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    case (state_q)
      IDLE, RUN: begin
        if (LoadStart) begin
          if (len_legal(LoadLength, MEM_BYTES)) begin
            start_ok = 1'b1;
            state_d  = LOAD;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      LOAD:    if (word_full) state_d = WRITE;
      WRITE:   state_d = last_word ? RUN : LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Address/length counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      len_q      <= '0;
      addr       <= BASE_ADDR;
      CoreRun    <= BOOT_RUN;
      LoadDone   <= 1'b0;
      LoadError  <= 1'b0;
    end else begin
      LoadDone <= 1'b0;
      if (start_ok) begin
        CoreRun   <= 1'b0;
        LoadError <= 1'b0;
        addr      <= BASE_ADDR;
        count     <= '0;
        len_q     <= LoadLength;
      end
      if (start_bad) LoadError <= 1'b1;
      if (accept)    count <= count + 1'b1;
      if (state_q == WRITE) begin
        addr <= addr + 32'd4;
        if (last_word) begin
          CoreRun  <= 1'b1;
          LoadDone <= 1'b1;
        end
      end
    end
  end

  // WRITE is a one-cycle bubble in the byte stream while the word goes to imem.
  assign ByteReady   = (state_q == LOAD);
  assign MemWrEn     = (state_q == WRITE);
  assign MemAddress  = (state_q == RUN) ? FetchAddress : addr;
  assign Instruction = (state_q == RUN) ? MemRdData : NOP_INSTR;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: two instances (BOOT_RUN=0 and BOOT_RUN=1).
module tb_imem_boot_loader;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk, rst_n;
  logic        LoadStart, ByteValid, ByteReady, MemWrEn, CoreRun, LoadDone, LoadError;
  logic [15:0] LoadLength;
  logic [7:0]  ByteData;
  logic [31:0] FetchAddress, Instruction, MemAddress, MemWrData, MemRdData;

  logic        b_start, b_valid, b_ready, b_wren, b_core, b_done, b_err;
  logic [15:0] b_len;
  logic [7:0]  b_data;
  logic [31:0] b_fetch, b_instr, b_maddr, b_wdata;
  logic [31:0] b_rd;

  int checks = 0;
  int errors = 0;

  imem_boot_loader #(.MEM_BYTES(256), .BASE_ADDR(32'h0), .BOOT_RUN(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .LoadStart(LoadStart), .LoadLength(LoadLength),
    .ByteData(ByteData), .ByteValid(ByteValid), .ByteReady(ByteReady),
    .FetchAddress(FetchAddress), .Instruction(Instruction), .MemAddress(MemAddress),
    .MemWrData(MemWrData), .MemWrEn(MemWrEn), .MemRdData(MemRdData),
    .CoreRun(CoreRun), .LoadDone(LoadDone), .LoadError(LoadError)
  );

  imem_boot_loader #(.MEM_BYTES(256), .BASE_ADDR(32'h0), .BOOT_RUN(1'b1)) dut_boot (
    .clk(clk), .rst_n(rst_n), .LoadStart(b_start), .LoadLength(b_len),
    .ByteData(b_data), .ByteValid(b_valid), .ByteReady(b_ready),
    .FetchAddress(b_fetch), .Instruction(b_instr), .MemAddress(b_maddr),
    .MemWrData(b_wdata), .MemWrEn(b_wren), .MemRdData(b_rd),
    .CoreRun(b_core), .LoadDone(b_done), .LoadError(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple imem model plus a log of every write the loader issues.
  logic [31:0] mem [0:63];
  logic [31:0] wr_addr [0:31];
  logic [31:0] wr_data [0:31];
  int          wr_cnt = 0;

  assign MemRdData = mem[MemAddress[7:2]];
  assign b_rd      = 32'hDEADBEEF;

  always @(posedge clk) begin
    if (MemWrEn) begin
      mem[MemAddress[7:2]] = MemWrData;
      wr_addr[wr_cnt]      = MemAddress;
      wr_data[wr_cnt]      = MemWrData;
      wr_cnt               = wr_cnt + 1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer one byte, wait (bounded) for ByteReady, let it be taken, then drop ByteValid.
  task automatic feed(input logic [7:0] b);
    int n;
    n = 0;
    ByteData  = b;
    ByteValid = 1'b1;
    while (!ByteReady && n < 20) begin
      tick;
      n++;
    end
    chk("feed_ready", {31'd0, ByteReady}, 32'd1);
    tick;
    ByteValid = 1'b0;
  endtask

  task automatic wait_done;
    int n;
    n = 0;
    while (!LoadDone && n < 20) begin
      tick;
      n++;
    end
    chk("load_done_seen", {31'd0, LoadDone}, 32'd1);
  endtask

  task automatic start(input logic [15:0] len);
    LoadLength = len;
    LoadStart  = 1'b1;
    tick;
    LoadStart  = 1'b0;
  endtask

  initial begin
    logic [7:0]  s1 [0:7];
    logic [7:0]  s4 [0:11];
    logic [31:0] base;

    s1 = '{8'h93, 8'h00, 8'h40, 8'h00, 8'h13, 8'h0B, 8'h20, 8'h00};
    s4 = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55,
           8'hCC, 8'hBB, 8'hAA, 8'h99};

    rst_n = 1'b0; LoadStart = 1'b0; LoadLength = '0; ByteData = '0; ByteValid = 1'b0;
    FetchAddress = '0;
    b_start = 1'b0; b_len = '0; b_data = '0; b_valid = 1'b0; b_fetch = 32'h10;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_corerun",   {31'd0, CoreRun},   32'd0);
    chk("rst_byteready", {31'd0, ByteReady}, 32'd0);
    chk("rst_wren",      {31'd0, MemWrEn},   32'd0);
    chk("rst_done",      {31'd0, LoadDone},  32'd0);
    chk("rst_err",       {31'd0, LoadError}, 32'd0);
    chk("rst_instr",     Instruction,        NOP);
    chk("rst_maddr",     MemAddress,         32'h0);
    chk("rst_boot_core", {31'd0, b_core},    32'd1);
    rst_n = 1'b1;
    tick;

    // Test 1: 8-byte load with ByteValid held high.
    start(16'd8);
    ByteValid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ByteData = s1[i];
      chk("t1_ready", {31'd0, ByteReady}, 32'd1);
      tick;
      if (i % 4 == 3) begin
        chk("t1_wren",    {31'd0, MemWrEn},   32'd1);
        chk("t1_wdata",   MemWrData,          (i == 3) ? 32'h00400093 : 32'h00200B13);
        chk("t1_waddr",   MemAddress,         (i == 3) ? 32'h0 : 32'h4);
        chk("t1_bubble",  {31'd0, ByteReady}, 32'd0);
        chk("t1_core_lo", {31'd0, CoreRun},   32'd0);
        chk("t1_done_lo", {31'd0, LoadDone},  32'd0);
        ByteData = 8'hEE;  // offered during WRITE, must not be taken
        tick;
      end
    end
    ByteValid = 1'b0;
    chk("t1_done",    {31'd0, LoadDone}, 32'd1);
    chk("t1_core",    {31'd0, CoreRun},  32'd1);
    chk("t1_nwrites", wr_cnt,            32'd2);
    tick;
    chk("t1_done_pulse", {31'd0, LoadDone}, 32'd0);
    chk("t1_core_hold",  {31'd0, CoreRun},  32'd1);

    // Test 2: fetch in RUN goes straight through.
    FetchAddress = 32'h4;
    #1;
    chk("t2_maddr", MemAddress,  32'h4);
    chk("t2_instr", Instruction, 32'h00200B13);

    // Test 3: illegal lengths flag an error and leave the core running.
    base = wr_cnt;
    start(16'd6);
    chk("t3_err6",  {31'd0, LoadError}, 32'd1);
    chk("t3_core6", {31'd0, CoreRun},   32'd1);
    start(16'd0);
    chk("t3_err0",  {31'd0, LoadError}, 32'd1);
    chk("t3_wren0", {31'd0, MemWrEn},   32'd0);
    start(16'd260);
    chk("t3_err260",  {31'd0, LoadError}, 32'd1);
    chk("t3_core260", {31'd0, CoreRun},   32'd1);
    chk("t3_instr",   Instruction,        32'h00200B13);
    tick;
    chk("t3_nowrites", wr_cnt - base, 32'd0);

    // Test 4: 12 bytes with random ByteValid gaps.
    base = wr_cnt;
    start(16'd12);
    chk("t4_err_clr", {31'd0, LoadError}, 32'd0);
    chk("t4_core_lo", {31'd0, CoreRun},   32'd0);
    chk("t4_instr",   Instruction,        NOP);
    chk("t4_maddr",   MemAddress,         32'h0);
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 2)) tick;
      feed(s4[i]);
    end
    wait_done;
    chk("t4_nwrites", wr_cnt - base,    32'd3);
    chk("t4_w0", wr_data[base],         32'h11223344);
    chk("t4_w1", wr_data[base + 1],     32'h55667788);
    chk("t4_w2", wr_data[base + 2],     32'h99AABBCC);
    chk("t4_a2", wr_addr[base + 2],     32'h8);
    chk("t4_core", {31'd0, CoreRun},    32'd1);

    // Test 5: reset in the middle of an 8-byte load, then a fresh 4-byte load.
    base = wr_cnt;
    start(16'd8);
    for (int i = 0; i < 5; i++) feed(8'hA0 + 8'(i));
    rst_n = 1'b0;
    #1;
    chk("t5_nwrites",  wr_cnt - base,      32'd1);
    chk("t5_w0",       wr_data[base],      32'hA3A2A1A0);
    chk("t5_core",     {31'd0, CoreRun},   32'd0);
    chk("t5_ready",    {31'd0, ByteReady}, 32'd0);
    chk("t5_wren",     {31'd0, MemWrEn},   32'd0);
    chk("t5_done",     {31'd0, LoadDone},  32'd0);
    chk("t5_err",      {31'd0, LoadError}, 32'd0);
    chk("t5_maddr",    MemAddress,         32'h0);
    chk("t5_instr",    Instruction,        NOP);
    #3;
    rst_n = 1'b1;
    tick;
    base = wr_cnt;
    start(16'd4);
    feed(8'h78); feed(8'h56); feed(8'h34); feed(8'h12);
    wait_done;
    chk("t5_fresh_n",    wr_cnt - base,    32'd1);
    chk("t5_fresh_data", wr_data[base],    32'h12345678);
    chk("t5_fresh_addr", wr_addr[base],    32'h0);
    chk("t5_fresh_core", {31'd0, CoreRun}, 32'd1);

    // Test 6: BOOT_RUN instance runs from reset; a load takes the core down until done.
    chk("t6_core_run", {31'd0, b_core}, 32'd1);
    chk("t6_instr_run", b_instr,        32'hDEADBEEF);
    chk("t6_maddr_run", b_maddr,        32'h10);
    b_len   = 16'd4;
    b_start = 1'b1;
    tick;
    b_start = 1'b0;
    chk("t6_core_lo",   {31'd0, b_core}, 32'd0);
    chk("t6_instr_nop", b_instr,         NOP);
    b_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_data = 8'h10 + 8'(i);
      tick;
    end
    b_valid = 1'b0;
    chk("t6_wren",      {31'd0, b_wren}, 32'd1);
    chk("t6_wdata",     b_wdata,         32'h13121110);
    chk("t6_instr_wr",  b_instr,         NOP);
    tick;
    chk("t6_done",      {31'd0, b_done}, 32'd1);
    chk("t6_core_hi",   {31'd0, b_core}, 32'd1);
    chk("t6_instr_end", b_instr,         32'hDEADBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
